// File: rtl/gen_env_adsr.sv
// Gate-driven ADSR amplitude envelope for the oscillator sample stream.
// The envelope advances once per 48 kHz strobe. Each strobe also scales the
// incoming sample by the envelope level as it stood before that strobe's update.
module gen_env_adsr #(
   parameter bit RETRIG_ZERO = 1'b0  // 1: gate rise restarts attack from zero
) (
   input  logic        i_clk48,
   input  logic        i_rst48_n,
   input  logic        i_pulse,
   input  logic [15:0] i_sample,
   input  logic        i_gate,
   input  logic [15:0] i_attack_step,
   input  logic [15:0] i_decay_step,
   input  logic [15:0] i_sustain_lvl,
   input  logic [15:0] i_release_step,
   output logic [15:0] o_sample,
   output logic        o_pulse,
   output logic [15:0] o_env,
   output logic        o_active
);

   typedef enum logic [2:0] {
      StIdle,
      StAttack,
      StDecay,
      StSustain,
      StRelease
   } state_e;

   state_e             state_q, state_d;
   logic        [15:0] env_q, env_d;
   logic        [15:0] sample_q, sample_d;
   logic               pulse_q;

   logic        [16:0] atk_sum;
   logic        [15:0] dec_diff;
   logic signed [31:0] smp_ext;
   logic signed [31:0] env_ext;
   logic signed [31:0] prod;

   // Envelope next-state: only a strobe moves the FSM, otherwise everything holds.
   always_comb begin
      state_d  = state_q;
      env_d    = env_q;
      atk_sum  = {1'b0, env_q} + {1'b0, i_attack_step};
      dec_diff = env_q - i_decay_step;
      if (i_pulse) begin
         if (!i_gate && (state_q != StIdle) && (state_q != StRelease)) begin
            // Note off: level is frozen for this strobe, release starts on the next.
            state_d = StRelease;
         end else if (i_gate && ((state_q == StIdle) || (state_q == StRelease))) begin
            state_d = StAttack;
            if (RETRIG_ZERO) begin
               env_d = 16'h0000;
            end
         end else begin
            unique case (state_q)
               StAttack: begin
                  if ((i_attack_step == 16'h0000) || (atk_sum >= 17'h0FFFF)) begin
                     env_d   = 16'hFFFF;
                     state_d = StDecay;
                  end else begin
                     env_d = atk_sum[15:0];
                  end
               end
               StDecay: begin
                  // Sustain at or above the current level ends decay at once.
                  if ((i_sustain_lvl >= env_q) || (i_decay_step == 16'h0000) ||
                      (env_q < i_decay_step) || (dec_diff <= i_sustain_lvl)) begin
                     env_d   = i_sustain_lvl;
                     state_d = StSustain;
                  end else begin
                     env_d = dec_diff;
                  end
               end
               StSustain: begin
                  env_d = i_sustain_lvl;
               end
               StRelease: begin
                  if ((i_release_step == 16'h0000) || (env_q <= i_release_step)) begin
                     env_d   = 16'h0000;
                     state_d = StIdle;
                  end else begin
                     env_d = env_q - i_release_step;
                  end
               end
               StIdle: begin
                  env_d = 16'h0000;
               end
               default: begin
                  env_d   = 16'h0000;
                  state_d = StIdle;
               end
            endcase
         end
      end
   end

   // Sample scaling: signed sample times unsigned envelope, floor of product / 2^16.
   // The full product always fits in 32 signed bits, so no saturation is needed.
   always_comb begin
      smp_ext  = {{16{i_sample[15]}}, i_sample};
      env_ext  = {16'h0000, env_q};
      prod     = smp_ext * env_ext;
      sample_d = i_pulse ? 16'(prod >>> 16) : sample_q;
   end

   // State, envelope and output registers; reset drops straight to idle.
   always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
      if (!i_rst48_n) begin
         state_q  <= StIdle;
         env_q    <= 16'h0000;
         sample_q <= 16'h0000;
         pulse_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         env_q    <= env_d;
         sample_q <= sample_d;
         pulse_q  <= i_pulse;
      end
   end

   assign o_sample = sample_q;
   assign o_pulse  = pulse_q;
   assign o_env    = env_q;
   assign o_active = (state_q != StIdle);

endmodule

// File: tb/tb_gen_env_adsr.sv
// Self-checking bench for gen_env_adsr: expected results are queued when a
// strobe is driven and compared when the DUT raises o_pulse.
module tb_gen_env_adsr;

   logic        clk;
   logic        rst_n;
   logic        pulse;
   logic [15:0] sample;
   logic        gate;
   logic [15:0] atk, dec, sus, rel;
   logic [15:0] o_sample;
   logic        o_pulse;
   logic [15:0] o_env;
   logic        o_active;

   gen_env_adsr #(
      .RETRIG_ZERO(1'b0)
   ) dut (
      .i_clk48       (clk),
      .i_rst48_n     (rst_n),
      .i_pulse       (pulse),
      .i_sample      (sample),
      .i_gate        (gate),
      .i_attack_step (atk),
      .i_decay_step  (dec),
      .i_sustain_lvl (sus),
      .i_release_step(rel),
      .o_sample      (o_sample),
      .o_pulse       (o_pulse),
      .o_env         (o_env),
      .o_active      (o_active)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   typedef struct {
      logic [15:0] xs;
      logic [15:0] xe;
      logic        xa;
      string       nm;
   } exp_t;

   typedef struct {
      logic        g;
      logic [15:0] smp;
      logic [15:0] atk;
      logic [15:0] dec;
      logic [15:0] sus;
      logic [15:0] rel;
      logic [15:0] xs;
      logic [15:0] xe;
      logic        xa;
   } vec_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic prev_pulse = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Pop and compare whenever the DUT announces a new output sample.
   always @(negedge clk) begin
      if (rst_n && o_pulse) begin
         chk("pulse_width", {31'd0, prev_pulse}, 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_pulse", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.nm, "/sample"}, {16'd0, o_sample}, {16'd0, e.xs});
            chk({e.nm, "/env"}, {16'd0, o_env}, {16'd0, e.xe});
            chk({e.nm, "/active"}, {31'd0, o_active}, {31'd0, e.xa});
         end
      end
      prev_pulse <= o_pulse;
   end

   // One strobe with its expected result; then checks latency and hold.
   task automatic strobe(input logic g, input logic [15:0] smp, input logic [15:0] a,
                         input logic [15:0] d, input logic [15:0] s, input logic [15:0] r,
                         input logic [15:0] xs, input logic [15:0] xe, input logic xa,
                         input string nm);
      exp_t e;
      @(negedge clk);
      gate   = g;
      sample = smp;
      atk    = a;
      dec    = d;
      sus    = s;
      rel    = r;
      pulse  = 1'b1;
      e.xs = xs;
      e.xe = xe;
      e.xa = xa;
      e.nm = nm;
      sb.push_back(e);
      @(posedge clk);
      #1 pulse = 1'b0;
      @(negedge clk);
      #1 chk({nm, "/latency"}, sb.size(), 32'd0);
      // Sample input changes between strobes must not reach the output.
      repeat (2) begin
         @(negedge clk);
         sample = 16'($urandom);
      end
      #1;
      chk({nm, "/hold"}, {15'd0, o_pulse, o_sample}, {16'd0, xs});
   endtask

   vec_t tbl[20];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] pre, post;

      tbl[0]  = '{1'b1, 16'h4000, 16'h1000, 16'h0800, 16'h8000, 16'h2000, 16'h2000, 16'h8000, 1'b1};
      tbl[1]  = '{1'b1, 16'hC000, 16'h1000, 16'h0800, 16'h8000, 16'h2000, 16'hE000, 16'h8000, 1'b1};
      tbl[2]  = '{1'b0, 16'h4000, 16'h1000, 16'h0800, 16'h8000, 16'h2000, 16'h2000, 16'h8000, 1'b1};
      tbl[3]  = '{1'b0, 16'h4000, 16'h1000, 16'h0800, 16'h8000, 16'h2000, 16'h2000, 16'h6000, 1'b1};
      tbl[4]  = '{1'b0, 16'h4000, 16'h1000, 16'h0800, 16'h8000, 16'h2000, 16'h1800, 16'h4000, 1'b1};
      tbl[5]  = '{1'b1, 16'h4000, 16'h1000, 16'h0800, 16'h8000, 16'h2000, 16'h1000, 16'h4000, 1'b1};
      tbl[6]  = '{1'b1, 16'h4000, 16'h0000, 16'h0800, 16'h8000, 16'h2000, 16'h1000, 16'hFFFF, 1'b1};
      tbl[7]  = '{1'b1, 16'h8000, 16'h0000, 16'h0800, 16'h8000, 16'h2000, 16'h8000, 16'hF7FF, 1'b1};
      tbl[8]  = '{1'b1, 16'h4000, 16'h0000, 16'h0800, 16'hFFFF, 16'h2000, 16'h3DFF, 16'hFFFF, 1'b1};
      tbl[9]  = '{1'b1, 16'h4000, 16'h0000, 16'h0800, 16'h1234, 16'h2000, 16'h3FFF, 16'h1234, 1'b1};
      tbl[10] = '{1'b1, 16'h4000, 16'h0000, 16'h0800, 16'h2000, 16'h2000, 16'h048D, 16'h2000, 1'b1};
      tbl[11] = '{1'b0, 16'h4000, 16'h0000, 16'h0800, 16'h2000, 16'h2000, 16'h0800, 16'h2000, 1'b1};
      tbl[12] = '{1'b0, 16'h4000, 16'h0000, 16'h0800, 16'h2000, 16'h2000, 16'h0800, 16'h0000, 1'b0};
      tbl[13] = '{1'b0, 16'h4000, 16'h0000, 16'h0800, 16'h2000, 16'h2000, 16'h0000, 16'h0000, 1'b0};
      tbl[14] = '{1'b1, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
      tbl[15] = '{1'b1, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 1'b1};
      tbl[16] = '{1'b1, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h3FFF, 16'h0000, 1'b1};
      tbl[17] = '{1'b1, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
      tbl[18] = '{1'b0, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1};
      tbl[19] = '{1'b0, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0};

      rst_n  = 1'b0;
      pulse  = 1'b0;
      sample = 16'h0000;
      gate   = 1'b0;
      atk    = 16'h0000;
      dec    = 16'h0000;
      sus    = 16'h0000;
      rel    = 16'h0000;
      repeat (3) @(negedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk);
      chk("reset/outputs", {o_sample, o_env}, 32'd0);
      chk("reset/flags", {30'd0, o_pulse, o_active}, 32'd0);

      // Gate low: nothing comes out but the strobe.
      for (int i = 0; i < 5; i++) begin
         strobe(1'b0, 16'h4000, 16'h1000, 16'h0800, 16'h8000, 16'h2000,
                16'h0000, 16'h0000, 1'b0, "idle");
      end

      // First gate-high strobe only enters attack.
      strobe(1'b1, 16'h4000, 16'h1000, 16'h0800, 16'h8000, 16'h2000,
             16'h0000, 16'h0000, 1'b1, "gate_on");
      for (int k = 1; k <= 16; k++) begin
         pre  = 16'((k - 1) * 32'h1000);
         post = (k < 16) ? 16'(k * 32'h1000) : 16'hFFFF;
         strobe(1'b1, 16'h4000, 16'h1000, 16'h0800, 16'h8000, 16'h2000,
                {2'b00, pre[15:2]}, post, 1'b1, $sformatf("attack%0d", k));
      end
      for (int n = 1; n <= 16; n++) begin
         pre  = 16'(32'hFFFF - (n - 1) * 32'h0800);
         post = (n < 16) ? 16'(32'hFFFF - n * 32'h0800) : 16'h8000;
         strobe(1'b1, 16'h4000, 16'h1000, 16'h0800, 16'h8000, 16'h2000,
                {2'b00, pre[15:2]}, post, 1'b1, $sformatf("decay%0d", n));
      end

      for (int i = 0; i < 20; i++) begin
         strobe(tbl[i].g, tbl[i].smp, tbl[i].atk, tbl[i].dec, tbl[i].sus, tbl[i].rel,
                tbl[i].xs, tbl[i].xe, tbl[i].xa, $sformatf("vec%0d", i));
      end

      // A gate blip between strobes is never seen.
      @(negedge clk) gate = 1'b1;
      @(negedge clk) gate = 1'b0;
      strobe(1'b0, 16'h4000, 16'h1000, 16'h0800, 16'h8000, 16'h2000,
             16'h0000, 16'h0000, 1'b0, "gate_blip");

      // Asynchronous reset in the middle of an attack.
      strobe(1'b1, 16'h4000, 16'h1000, 16'h0800, 16'h8000, 16'h2000,
             16'h0000, 16'h0000, 1'b1, "pre_rst0");
      strobe(1'b1, 16'h4000, 16'h1000, 16'h0800, 16'h8000, 16'h2000,
             16'h0000, 16'h1000, 1'b1, "pre_rst1");
      strobe(1'b1, 16'h4000, 16'h1000, 16'h0800, 16'h8000, 16'h2000,
             16'h0400, 16'h2000, 1'b1, "pre_rst2");
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst/outputs", {o_sample, o_env}, 32'd0);
      chk("async_rst/flags", {30'd0, o_pulse, o_active}, 32'd0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      strobe(1'b1, 16'h4000, 16'h1000, 16'h0800, 16'h8000, 16'h2000,
             16'h0000, 16'h0000, 1'b1, "post_rst0");
      strobe(1'b1, 16'h4000, 16'h1000, 16'h0800, 16'h8000, 16'h2000,
             16'h0000, 16'h1000, 1'b1, "post_rst1");

      repeat (3) @(negedge clk);
      chk("scoreboard_drain", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
